io_config_bank_writer: RTL and testbench

//  Configuration-bus initiator for IO grid tiles. Takes a serial configuration bitstream on a

---
 rtl/io_config_bank_writer.sv | 155 +++++++++++++++
 tb/tb_io_config_bank_writer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_config_bank_writer.sv
// io_config_bank_writer
//   Configuration-bus initiator for IO grid tiles. Accepts a serial bitstream
//   on a valid/ready stream and writes one configuration cell per bit. For
//   each bit it sets up address/data_in, pulses enable for one cycle, and
//   then holds the bus. The address auto-increments over NUM_WORDS cells per
//   frame.
//
// Ports
//   prog_clk  in   programming clock, rising edge
//   pReset    in   synchronous active-high reset
//   start     in   1-cycle pulse, begins a frame when idle
//   abort     in   synchronous abort, back to idle next cycle
//   in_valid  in   bitstream bit valid
//   in_data   in   bitstream bit
//   in_ready  out  high only while waiting for a bit (FETCH)
//   enable    out  one-cycle write strobe to the tile decoder
//   address   out  [0:ADDR_WIDTH-1] target cell; [0]=cell, [1:]=tile (MSB first)
//   data_in   out  configuration bit for the addressed cell
//   busy      out  high from start acceptance until the frame ends
//   done      out  1-cycle pulse after the last strobe+hold of a frame
module io_config_bank_writer #(
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_WORDS    = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic                  in_data,
  output logic                  in_ready,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(NUM_WORDS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] word;
  logic [CNT_W-1:0]      cnt;

  // Word counter to bus address: bit 0 selects the cell, the remaining
  // address bits carry the tile index with its MSB at address[1].
  function automatic logic [0:ADDR_WIDTH-1] map_addr(input logic [ADDR_WIDTH-1:0] w);
    logic [0:ADDR_WIDTH-1] a;
    a    = '0;
    a[0] = w[0];
    for (int unsigned i = 1; i < ADDR_WIDTH; i++) begin
      a[i] = w[ADDR_WIDTH-i];
    end
    return a;
  endfunction

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state    <= S_IDLE;
      word     <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
      enable   <= 1'b0;
      address  <= '0;
      data_in  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      // address/data_in deliberately keep their values on abort
      state    <= S_IDLE;
      cnt      <= '0;
      in_ready <= 1'b0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_FETCH;
            word     <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            data_in  <= in_data;
            address  <= map_addr(word);
            in_ready <= 1'b0;
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            enable <= 1'b1;
            state  <= S_STROBE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STROBE: begin
          enable <= 1'b0;
          cnt    <= '0;
          state  <= (HOLD_CYCLES == 0) ? S_NEXT : S_HOLD;
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (word == LAST_WORD) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            word     <= word + ADDR_WIDTH'(1);
            in_ready <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_config_bank_writer.sv
module tb_io_config_bank_writer;
  localparam int AW      = 4;
  localparam int SETUP_A = 1;
  localparam int SETUP_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          pReset = 1'b1;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, in_data = 1'b0;
  logic          in_ready, enable, data_in, busy, done;
  logic [0:AW-1] address;

  logic          b_start = 1'b0, b_abort = 1'b0, b_in_valid = 1'b0, b_in_data = 1'b0;
  logic          b_in_ready, b_enable, b_data_in, b_busy, b_done;
  logic [0:AW-1] b_address;

  io_config_bank_writer #(
    .ADDR_WIDTH(AW), .NUM_WORDS(16), .SETUP_CYCLES(SETUP_A), .HOLD_CYCLES(1)
  ) dut (
    .prog_clk(clk), .pReset(pReset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .enable(enable), .address(address), .data_in(data_in),
    .busy(busy), .done(done)
  );

  io_config_bank_writer #(
    .ADDR_WIDTH(AW), .NUM_WORDS(3), .SETUP_CYCLES(SETUP_B), .HOLD_CYCLES(0)
  ) dut_b (
    .prog_clk(clk), .pReset(pReset), .start(b_start), .abort(b_abort),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .enable(b_enable), .address(b_address), .data_in(b_data_in),
    .busy(b_busy), .done(b_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word n lands on cell n%2 of tile n/2; with address read
  // as a number (address[0] most significant) that is (n%2)<<(AW-1) | n/2.
  function automatic int model_addr(input int n);
    return ((n % 2) << (AW - 1)) | (n / 2);
  endfunction

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   frame_n = 0;
  int   bn = 0;
  int   frame_base = 0;
  logic stop_feed = 1'b0;

  // ---------------- monitor, instance A ----------------
  int   strobes_a = 0;
  int   done_a = 0;
  logic prev_en_a = 1'b0;
  int   frame_addr[16];

  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (enable === 1'b1) begin
      chk("a_no_back_to_back", prev_en_a, 0);
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_strobe actual=strobe required=none (cycle %0d)", cyc);
      end else begin
        e = qa.pop_front();
        chk("a_strobe_addr", int'(address), e.addr);
        chk("a_strobe_data", data_in, e.data);
        chk("a_strobe_latency", cyc, e.cyc);
      end
      idx = strobes_a - frame_base;
      if (idx >= 0 && idx < 16) frame_addr[idx] = int'(address);
      strobes_a++;
    end
    if (done === 1'b1) begin
      done_a++;
      chk("a_queue_empty_at_done", qa.size(), 0);
    end
    prev_en_a = enable;
  end

  // ---------------- monitor, instance B ----------------
  int   strobes_b = 0;
  int   done_b = 0;
  logic prev_en_b = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (b_enable === 1'b1) begin
      chk("b_no_back_to_back", prev_en_b, 0);
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_strobe actual=strobe required=none (cycle %0d)", cyc);
      end else begin
        e = qb.pop_front();
        chk("b_strobe_addr", int'(b_address), e.addr);
        chk("b_strobe_data", b_data_in, e.data);
        chk("b_strobe_latency", cyc, e.cyc);
      end
      strobes_b++;
    end
    if (b_done === 1'b1) begin
      done_b++;
      chk("b_strobes_at_done", strobes_b, 3);
    end
    prev_en_b = b_enable;
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic feed_bit(input logic b);
    int   waited;
    logic acc;
    exp_t e;
    waited = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    while (!acc && !stop_feed && waited < 200) begin
      @(negedge clk);
      if (stop_feed) break;
      if (in_ready === 1'b1) begin
        e.addr = model_addr(frame_n);
        e.data = int'(b);
        e.cyc  = cyc + SETUP_A + 1;
        qa.push_back(e);
        frame_n++;
        acc = 1'b1;
      end
      waited++;
    end
    if (acc) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!stop_feed) chk("a_accept_within_bound", acc, 1);
  endtask

  task automatic feed_bit_b(input logic b);
    int   waited;
    logic acc;
    exp_t e;
    waited = 0;
    acc = 1'b0;
    b_in_valid = 1'b1;
    b_in_data = b;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (b_in_ready === 1'b1) begin
        e.addr = model_addr(bn);
        e.data = int'(b);
        e.cyc  = cyc + SETUP_B + 1;
        qb.push_back(e);
        bn++;
        acc = 1'b1;
      end
      waited++;
    end
    if (acc) begin
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    chk("b_accept_within_bound", acc, 1);
  endtask

  // Idle DUT accepts start and restarts its word count; a busy one ignores it.
  task automatic pulse_start(input logic idle);
    @(posedge clk);
    #1;
    start = 1'b1;
    if (idle) begin
      frame_n = 0;
      frame_base = strobes_a;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_a;
    n = 0;
    while (done_a == d0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_done_seen"}, done_a - d0, 1);
    chk({name, "_busy_during_done"}, busy, 1);
    @(negedge clk);
    chk({name, "_busy_after_done"}, busy, 0);
    chk({name, "_done_is_pulse"}, done, 0);
    repeat (5) @(negedge clk);
    chk({name, "_single_done"}, done_a - d0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] pat;
    logic [0:AW-1] snap_addr;
    logic snap_data;
    int d0;
    int k;
    pat = 16'b1010_0110_1100_0011;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enable", enable, 0);
    chk("rst_address", int'(address), 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_b_busy", b_busy, 0);
    @(posedge clk);
    #1;
    pReset = 1'b0;

    // T1 full frame, in_valid held high; T2 mapping spot checks
    pulse_start(1'b1);
    for (int i = 0; i < 16; i++) feed_bit(pat[15-i]);
    wait_done("t1");
    chk("t1_strobe_count", strobes_a - frame_base, 16);
    chk("t2_addr_n0", frame_addr[0], 0);
    chk("t2_addr_n5", frame_addr[5], 4'b1010);
    chk("t2_addr_n14", frame_addr[14], 4'b0111);
    chk("t2_addr_n15", frame_addr[15], 4'b1111);

    // T3 backpressure before bit 4, random bits and gaps elsewhere
    pulse_start(1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
          @(negedge clk);
          k++;
        end
        snap_addr = address;
        snap_data = data_in;
        for (int s = 0; s < 7; s++) begin
          if (s > 0) @(negedge clk);
          chk("t3_stall_enable", enable, 0);
          chk("t3_stall_in_ready", in_ready, 1);
          chk("t3_stall_addr", int'(address), int'(snap_addr));
          chk("t3_stall_data", data_in, snap_data);
        end
        @(posedge clk);
        #1;
      end else begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      feed_bit(1'($urandom));
    end
    wait_done("t3");
    chk("t3_strobe_count", strobes_a - frame_base, 16);

    // T4 abort one cycle after the 9th strobe
    pulse_start(1'b1);
    d0 = done_a;
    stop_feed = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          if (stop_feed) break;
          feed_bit(1'($urandom));
        end
      end
      begin
        k = 0;
        while (strobes_a - frame_base < 9 && k < 500) begin
          @(negedge clk);
          #1;
          k++;
        end
        chk("t4_ninth_strobe_seen", strobes_a - frame_base, 9);
        @(posedge clk);
        #1;
        abort = 1'b1;
        stop_feed = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t4_busy_after_abort", busy, 0);
        chk("t4_enable_after_abort", enable, 0);
        chk("t4_in_ready_after_abort", in_ready, 0);
        chk("t4_done_after_abort", done, 0);
      end
    join
    repeat (20) @(negedge clk);
    chk("t4_no_more_strobes", strobes_a - frame_base, 9);
    chk("t4_no_done", done_a - d0, 0);
    chk("t4_queue_empty", qa.size(), 0);
    stop_feed = 1'b0;
    @(posedge clk);
    #1;
    pulse_start(1'b1);
    for (int i = 0; i < 16; i++) feed_bit(1'($urandom));
    wait_done("t4b");
    chk("t4b_first_addr", frame_addr[0], 0);
    chk("t4b_strobe_count", strobes_a - frame_base, 16);

    // T5 reset during SETUP of bit 3, then start-while-busy ignored
    pulse_start(1'b1);
    d0 = done_a;
    for (int i = 0; i < 4; i++) feed_bit(1'b1);
    pReset = 1'b1;
    @(posedge clk);
    #1;
    pReset = 1'b0;
    @(negedge clk);
    chk("t5_rst_enable", enable, 0);
    chk("t5_rst_address", int'(address), 0);
    chk("t5_rst_data_in", data_in, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    qa.delete();
    repeat (10) @(negedge clk);
    chk("t5_strobes_before_reset", strobes_a - frame_base, 3);
    chk("t5_no_done", done_a - d0, 0);
    @(posedge clk);
    #1;
    pulse_start(1'b1);
    for (int i = 0; i < 2; i++) feed_bit(1'($urandom));
    pulse_start(1'b0);
    for (int i = 2; i < 16; i++) feed_bit(1'($urandom));
    wait_done("t5");
    chk("t5_strobe_count", strobes_a - frame_base, 16);
    chk("t5_addr_n2", frame_addr[2], 4'b0001);

    // T6 SETUP=2, HOLD=0, NUM_WORDS=3 on the second instance
    @(posedge clk);
    #1;
    b_start = 1'b1;
    bn = 0;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    feed_bit_b(1'b1);
    feed_bit_b(1'b0);
    feed_bit_b(1'b1);
    k = 0;
    while (done_b == 0 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    repeat (10) @(negedge clk);
    chk("t6_strobe_count", strobes_b, 3);
    chk("t6_single_done", done_b, 1);
    chk("t6_busy_low", b_busy, 0);
    chk("t6_queue_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
